// File: rtl/dp_constants.sv
// Shared constants for the debug TAP instruction path: DR-select encoding and decoder result.
package dp_constants;

   localparam int unsigned SEL_W = 4;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_BYPASS = 4'h0;
   localparam sel_t SEL_IDCODE = 4'h1;
   localparam sel_t SEL_DTMCS  = 4'h2;
   localparam sel_t SEL_DMI    = 4'h3;

endpackage

// File: rtl/dp_ir_match.sv
// Combinational opcode decoder: maps an IR value to a DR select and an implemented flag.
module dp_ir_match
   import dp_constants::*;
#(
   parameter int unsigned     IR_W      = 5,
   parameter logic [IR_W-1:0] OP_IDCODE = 'h01,
   parameter logic [IR_W-1:0] OP_DTMCS  = 'h10,
   parameter logic [IR_W-1:0] OP_DMI    = 'h11,
   parameter logic [IR_W-1:0] RSV_LO    = 'h12,
   parameter logic [IR_W-1:0] RSV_HI    = 'h17
) (
   input  logic [IR_W-1:0] op,
   output logic            impl,
   output sel_t            sel
);

   // First match wins; unknown opcodes still route to bypass but are flagged.
   always_comb begin
      impl = 1'b1;
      sel  = SEL_BYPASS;
      if (op == OP_IDCODE) begin
         sel = SEL_IDCODE;
      end else if (op == OP_DTMCS) begin
         sel = SEL_DTMCS;
      end else if (op == OP_DMI) begin
         sel = SEL_DMI;
      end else if (op == '0 || op == '1) begin
         sel = SEL_BYPASS;
      end else if (op >= RSV_LO && op <= RSV_HI) begin
         sel = SEL_BYPASS;
      end else begin
         impl = 1'b0;
      end
   end

endmodule

// File: rtl/dp_ir_reg.sv
// JTAG instruction register: capture/shift chain, update register and registered decode.
module dp_ir_reg
   import dp_constants::*;
#(
   parameter int unsigned     IR_W      = 5,
   parameter logic [IR_W-1:0] OP_IDCODE = 'h01,
   parameter logic [IR_W-1:0] OP_DTMCS  = 'h10,
   parameter logic [IR_W-1:0] OP_DMI    = 'h11,
   parameter logic [IR_W-1:0] RSV_LO    = 'h12,
   parameter logic [IR_W-1:0] RSV_HI    = 'h17
) (
   input  logic            tck,
   input  logic            trst_n,
   input  logic            tlr,
   input  logic            capture_ir,
   input  logic            shift_ir,
   input  logic            update_ir,
   input  logic            tdi,
   output logic            tdo_ir,
   output logic [IR_W-1:0] ir_q,
   output sel_t            bsr_sel,
   output logic            ir_upd,
   output logic            bad_ir
);

   // Mandatory xx01 capture pattern, sized without a zero-width replication at IR_W == 2.
   localparam logic [IR_W-1:0] CAPTURE_VAL = IR_W'(2'b01);

   logic [IR_W-1:0] shift_q, shift_d;
   logic [IR_W-1:0] ir_d;
   sel_t            sel_d;
   logic            upd_d;
   logic            bad_d;
   logic            m_impl;
   sel_t            m_sel;

   dp_ir_match #(
      .IR_W      (IR_W),
      .OP_IDCODE (OP_IDCODE),
      .OP_DTMCS  (OP_DTMCS),
      .OP_DMI    (OP_DMI),
      .RSV_LO    (RSV_LO),
      .RSV_HI    (RSV_HI)
   ) u_match (
      .op   (shift_q),
      .impl (m_impl),
      .sel  (m_sel)
   );

   // Priority: tlr > update > capture > shift. ir_q/bsr_sel only move on update.
   always_comb begin
      shift_d = shift_q;
      ir_d    = ir_q;
      sel_d   = bsr_sel;
      upd_d   = 1'b0;
      bad_d   = bad_ir;
      if (tlr) begin
         shift_d = OP_IDCODE;
         ir_d    = OP_IDCODE;
         sel_d   = SEL_IDCODE;
         bad_d   = 1'b0;
      end else if (update_ir) begin
         ir_d  = shift_q;
         sel_d = m_sel;
         upd_d = 1'b1;
         bad_d = bad_ir | ~m_impl;
      end else if (capture_ir) begin
         shift_d = CAPTURE_VAL;
      end else if (shift_ir) begin
         shift_d = {tdi, shift_q[IR_W-1:1]};
      end
   end

   always_ff @(posedge tck) begin
      if (!trst_n) begin
         shift_q <= OP_IDCODE;
         ir_q    <= OP_IDCODE;
         bsr_sel <= SEL_IDCODE;
         ir_upd  <= 1'b0;
         bad_ir  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         ir_q    <= ir_d;
         bsr_sel <= sel_d;
         ir_upd  <= upd_d;
         bad_ir  <= bad_d;
      end
   end

   assign tdo_ir = shift_q[0];

endmodule

// File: tb/tb_dp_ir_reg.sv
// Directed bench for dp_ir_reg: a default 5-bit instance and an 8-bit instance on shared inputs.
module tb_dp_ir_reg;
   import dp_constants::*;

   logic       tck = 1'b0;
   logic       trst_n, tlr, capture_ir, shift_ir, update_ir, tdi;
   logic       tdo_ir, ir_upd, bad_ir;
   logic [4:0] ir_q;
   sel_t       bsr_sel;
   logic       tdo8, upd8, bad8;
   logic [7:0] ir8;
   sel_t       sel8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 tck = ~tck;

   dp_ir_reg u_dut (
      .tck        (tck),
      .trst_n     (trst_n),
      .tlr        (tlr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .tdi        (tdi),
      .tdo_ir     (tdo_ir),
      .ir_q       (ir_q),
      .bsr_sel    (bsr_sel),
      .ir_upd     (ir_upd),
      .bad_ir     (bad_ir)
   );

   dp_ir_reg #(
      .IR_W      (8),
      .OP_IDCODE (8'h01),
      .OP_DTMCS  (8'h10),
      .OP_DMI    (8'h11),
      .RSV_LO    (8'h12),
      .RSV_HI    (8'h17)
   ) u_dut8 (
      .tck        (tck),
      .trst_n     (trst_n),
      .tlr        (tlr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .tdi        (tdi),
      .tdo_ir     (tdo8),
      .ir_q       (ir8),
      .bsr_sel    (sel8),
      .ir_upd     (upd8),
      .bad_ir     (bad8)
   );

   typedef struct packed {
      logic       t, c, s, u, d;
      logic       e_tdo;
      logic [4:0] e_ir;
      sel_t       e_sel;
      logic       e_upd, e_bad;
   } vec_t;

   typedef struct packed {
      logic [7:0] op;
      sel_t       sel;
      logic       bad;
   } opv_t;

   vec_t tbl [9];
   opv_t ops5 [10];
   opv_t ops8 [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic t, input logic c, input logic s, input logic u,
                       input logic d);
      @(negedge tck);
      tlr = t; capture_ir = c; shift_ir = s; update_ir = u; tdi = d;
      @(posedge tck);
      #1;
   endtask

   task automatic load(input logic [7:0] op, input int w);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < w; i++) step(0, 0, 1, 0, op[i]);
      step(0, 0, 0, 1, 0);
   endtask

   initial begin
      // capture then shift 5'h11 LSB first, update, idle
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'h01, SEL_IDCODE, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'h11, SEL_DMI,    1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h11, SEL_DMI,    1'b0, 1'b0};

      ops5[0] = '{8'h15, SEL_BYPASS, 1'b0};
      ops5[1] = '{8'h1F, SEL_BYPASS, 1'b0};
      ops5[2] = '{8'h00, SEL_BYPASS, 1'b0};
      ops5[3] = '{8'h12, SEL_BYPASS, 1'b0};
      ops5[4] = '{8'h17, SEL_BYPASS, 1'b0};
      ops5[5] = '{8'h01, SEL_IDCODE, 1'b0};
      ops5[6] = '{8'h10, SEL_DTMCS,  1'b0};
      ops5[7] = '{8'h11, SEL_DMI,    1'b0};
      ops5[8] = '{8'h0A, SEL_BYPASS, 1'b1};
      ops5[9] = '{8'h10, SEL_DTMCS,  1'b1};

      ops8[0] = '{8'h11, SEL_DMI,    1'b0};
      ops8[1] = '{8'hFF, SEL_BYPASS, 1'b0};
      ops8[2] = '{8'h80, SEL_BYPASS, 1'b1};

      trst_n = 1'b0; tlr = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0;
      update_ir = 1'b0; tdi = 1'b0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      trst_n = 1'b1;

      chk("rst_tdo",  32'(tdo_ir),  32'd1);
      chk("rst_ir",   32'(ir_q),    32'h01);
      chk("rst_sel",  32'(bsr_sel), 32'(SEL_IDCODE));
      chk("rst_upd",  32'(ir_upd),  32'd0);
      chk("rst_bad",  32'(bad_ir),  32'd0);
      chk("rst_ir8",  32'(ir8),     32'h01);
      chk("rst_sel8", 32'(sel8),    32'(SEL_IDCODE));
      chk("rst_bad8", 32'(bad8),    32'd0);

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].t, tbl[i].c, tbl[i].s, tbl[i].u, tbl[i].d);
         chk($sformatf("seq%0d_tdo", i), 32'(tdo_ir),  32'(tbl[i].e_tdo));
         chk($sformatf("seq%0d_ir", i),  32'(ir_q),    32'(tbl[i].e_ir));
         chk($sformatf("seq%0d_sel", i), 32'(bsr_sel), 32'(tbl[i].e_sel));
         chk($sformatf("seq%0d_upd", i), 32'(ir_upd),  32'(tbl[i].e_upd));
         chk($sformatf("seq%0d_bad", i), 32'(bad_ir),  32'(tbl[i].e_bad));
      end

      for (int i = 0; i < 10; i++) begin
         load(ops5[i].op, 5);
         chk($sformatf("op%02h_ir", ops5[i].op),  32'(ir_q),    32'(ops5[i].op[4:0]));
         chk($sformatf("op%02h_sel", ops5[i].op), 32'(bsr_sel), 32'(ops5[i].sel));
         chk($sformatf("op%02h_upd", ops5[i].op), 32'(ir_upd),  32'd1);
         chk($sformatf("op%02h_bad", ops5[i].op), 32'(bad_ir),  32'(ops5[i].bad));
         step(0, 0, 0, 0, 0);
         chk($sformatf("op%02h_upd_drop", ops5[i].op), 32'(ir_upd), 32'd0);
      end

      // tlr in the middle of a shift discards everything and clears the sticky flag
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(1, 0, 1, 0, 1);
      chk("tlr_ir",  32'(ir_q),    32'h01);
      chk("tlr_sel", 32'(bsr_sel), 32'(SEL_IDCODE));
      chk("tlr_bad", 32'(bad_ir),  32'd0);
      chk("tlr_upd", 32'(ir_upd),  32'd0);
      chk("tlr_tdo", 32'(tdo_ir),  32'd1);
      step(0, 1, 0, 0, 0);
      chk("recap_tdo0", 32'(tdo_ir), 32'd1);
      step(0, 0, 1, 0, 0);
      chk("recap_tdo1", 32'(tdo_ir), 32'd0);
      load(8'h18, 5);
      chk("rsv_above_sel", 32'(bsr_sel), 32'(SEL_BYPASS));
      chk("rsv_above_bad", 32'(bad_ir),  32'd1);

      // update and capture together: update wins, shift chain keeps 5'h11
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, (i == 0 || i == 4));
      step(0, 1, 0, 1, 0);
      chk("pri_ir",  32'(ir_q),    32'h11);
      chk("pri_sel", 32'(bsr_sel), 32'(SEL_DMI));
      chk("pri_upd", 32'(ir_upd),  32'd1);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      chk("pri_no_recap", 32'(tdo_ir), 32'd1);

      // reset beats a simultaneous update
      load(8'h0A, 5);
      chk("pre_rst_bad", 32'(bad_ir), 32'd1);
      @(negedge tck);
      trst_n = 1'b0; update_ir = 1'b1;
      @(posedge tck);
      #1;
      chk("rstupd_ir",  32'(ir_q),    32'h01);
      chk("rstupd_sel", 32'(bsr_sel), 32'(SEL_IDCODE));
      chk("rstupd_upd", 32'(ir_upd),  32'd0);
      chk("rstupd_bad", 32'(bad_ir),  32'd0);
      chk("rstupd_tdo", 32'(tdo_ir),  32'd1);
      trst_n = 1'b1;
      update_ir = 1'b0;

      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         load(ops8[i].op, 8);
         chk($sformatf("w8_%02h_ir", ops8[i].op),  32'(ir8),  32'(ops8[i].op));
         chk($sformatf("w8_%02h_sel", ops8[i].op), 32'(sel8), 32'(ops8[i].sel));
         chk($sformatf("w8_%02h_upd", ops8[i].op), 32'(upd8), 32'd1);
         chk($sformatf("w8_%02h_bad", ops8[i].op), 32'(bad8), 32'(ops8[i].bad));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
